// File: rtl/mfp_ahb_port_write_arbiter_if.sv
// Client req/ack handshakes plus the AHB-Lite master segment toward the port slave.
// The master modport is the arbiter's view; slave is the clients' and bus slave's view.
interface mfp_ahb_port_write_arbiter_if;
  logic        req0;
  logic        req1;
  logic        sel0;
  logic        sel1;
  logic [15:0] data0;
  logic [15:0] data1;
  logic        ack0;
  logic        ack1;
  logic        err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  req0, req1, sel0, sel1, data0, data1, HREADY, HRESP,
    output ack0, ack1, err, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HSEL, HWDATA
  );

  modport slave (
    output req0, req1, sel0, sel1, data0, data1, HREADY, HRESP,
    input  ack0, ack1, err, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HSEL, HWDATA
  );
endinterface

// File: rtl/mfp_ahb_port_write_arbiter.sv
// Round-robin scheduler turning two client single-write requests into
// non-overlapping AHB-Lite single write transfers to the port0/port1 slave.
//
// state | meaning
// IDLE  | no transfer; arbitrate and latch the winner's address/data
// ADDR  | NONSEQ address phase for the granted client, held while HREADY=0
// DATA  | write data phase; ack/err to the granted client when HREADY=1
module mfp_ahb_port_write_arbiter #(
  parameter logic [31:0] PORT0_ADDR = 32'hffff0000,
  parameter logic [31:0] PORT1_ADDR = 32'hffff0002
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  mfp_ahb_port_write_arbiter_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        grant_id;
  logic        grant_nxt;
  logic        grant_en;
  logic        last_grant;
  logic [31:0] addr_q;
  logic [15:0] data_q;
  logic        done;

  // Tie goes to whichever client was not served last.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          grant_nxt = ~last_grant;
          grant_en  = 1'b1;
        end else if (bus.req0) begin
          grant_nxt = 1'b0;
          grant_en  = 1'b1;
        end else if (bus.req1) begin
          grant_nxt = 1'b1;
          grant_en  = 1'b1;
        end
        if (grant_en) begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (bus.HREADY) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bus.HREADY) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign done = (state == DATA) && bus.HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= 32'h0;
      data_q     <= 16'h0;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        grant_id <= grant_nxt;
        if (grant_nxt) begin
          addr_q <= bus.sel1 ? PORT1_ADDR : PORT0_ADDR;
          data_q <= bus.data1;
        end else begin
          addr_q <= bus.sel0 ? PORT1_ADDR : PORT0_ADDR;
          data_q <= bus.data0;
        end
      end
      if (done) begin
        last_grant <= grant_id;
      end
    end
  end

  // The slave always takes HWDATA[15:0], whichever port is addressed.
  assign bus.HADDR  = addr_q;
  assign bus.HTRANS = (state == ADDR) ? 2'b10 : 2'b00;
  assign bus.HWRITE = (state == ADDR);
  assign bus.HSEL   = (state == ADDR);
  assign bus.HSIZE  = 3'b001;
  assign bus.HBURST = 3'b000;
  assign bus.HWDATA = (state == DATA) ? {16'h0, data_q} : 32'h0;

  assign bus.ack0 = done && !grant_id;
  assign bus.ack1 = done && grant_id;
  assign bus.err  = done && bus.HRESP;

endmodule

// File: tb/tb_mfp_ahb_port_write_arbiter.sv
// Directed and randomized bench for the two-client AHB port write arbiter,
// with a transaction-level reference model and a small port0/port1 slave.
module tb_mfp_ahb_port_write_arbiter;
  localparam logic [31:0] P0 = 32'hffff0000;
  localparam logic [31:0] P1 = 32'hffff0002;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  mfp_ahb_port_write_arbiter_if bus();

  mfp_ahb_port_write_arbiter #(.PORT0_ADDR(P0), .PORT1_ADDR(P1)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );

  logic        r_req [2];
  logic        r_sel [2];
  logic [15:0] r_data [2];
  logic        hready;
  logic        hresp;

  assign bus.req0   = r_req[0];
  assign bus.req1   = r_req[1];
  assign bus.sel0   = r_sel[0];
  assign bus.sel1   = r_sel[1];
  assign bus.data0  = r_data[0];
  assign bus.data1  = r_data[1];
  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;

  // Port slave: captures HWDATA[15:0] at the end of an accepted data phase.
  logic [15:0] port0, port1;
  logic        pend;
  logic [31:0] paddr;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend  <= 1'b0;
      paddr <= 32'h0;
    end else begin
      if (pend && hready) begin
        if (paddr == P0) port0 <= bus.HWDATA[15:0];
        else             port1 <= bus.HWDATA[15:0];
        pend <= 1'b0;
      end
      if (bus.HSEL && bus.HTRANS == 2'b10 && hready) begin
        pend  <= 1'b1;
        paddr <= bus.HADDR;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one transaction at a time, finished after two HREADY-high
  // bus cycles following the grant cycle; winner chosen by round-robin rule.
  logic        m_busy;
  int          m_ready;
  int          m_cur;
  int          m_last;
  logic [31:0] m_addr;
  logic [15:0] m_data;
  logic        ackd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_ready = 0;
    m_cur   = 0;
    m_last  = 1;
    ackd[0] = 1'b0;
    ackd[1] = 1'b0;
  endtask

  task automatic eval();
    logic       e0, e1, ee;
    logic [1:0] etr;
    #1;
    e0 = 1'b0; e1 = 1'b0; ee = 1'b0; etr = 2'b00;
    if (!m_busy) begin
      if (r_req[0] || r_req[1]) begin
        m_cur   = (r_req[0] && r_req[1]) ? 1 - m_last : (r_req[0] ? 0 : 1);
        m_addr  = r_sel[m_cur] ? P1 : P0;
        m_data  = r_data[m_cur];
        m_busy  = 1'b1;
        m_ready = 0;
      end
    end else if (m_ready == 0) begin
      etr = 2'b10;
      chk("haddr", bus.HADDR, m_addr);
      if (hready) m_ready = 1;
    end else begin
      chk("hwdata", bus.HWDATA, {16'h0, m_data});
      if (hready) begin
        e0 = (m_cur == 0);
        e1 = (m_cur == 1);
        ee = hresp;
        m_busy = 1'b0;
        m_last = m_cur;
      end
    end
    chk("ctl", 32'({bus.ack0, bus.ack1, bus.err, bus.HSEL, bus.HWRITE, bus.HTRANS}),
        32'({e0, e1, ee, etr[1], etr[1], etr}));
    chk("ack_excl", 32'(bus.ack0 & bus.ack1), 32'd0);
    ackd[0] = e0;
    ackd[1] = e1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, 32'({bus.ack0, bus.ack1, bus.err, bus.HSEL, bus.HWRITE, bus.HTRANS}), 32'd0);
    chk({tag, "_haddr"}, bus.HADDR, 32'h0);
    chk({tag, "_hwdata"}, bus.HWDATA, 32'h0);
    chk({tag, "_hsize_hburst"}, 32'({bus.HSIZE, bus.HBURST}), 32'({3'b001, 3'b000}));
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("rst");
    tick();
    HRESETn = 1'b1;
    model_reset();
  endtask

  task automatic rand_clients();
    for (int i = 0; i < 2; i++) begin
      if (ackd[i]) begin
        if ($urandom_range(1) == 0) r_req[i] = 1'b0;
        else begin
          r_sel[i]  = 1'($urandom_range(1));
          r_data[i] = 16'($urandom);
        end
      end else if (!r_req[i]) begin
        if ($urandom_range(2) == 0) begin
          r_req[i]  = 1'b1;
          r_sel[i]  = 1'($urandom_range(1));
          r_data[i] = 16'($urandom);
        end
      end else if (!(m_busy && m_cur == i) && $urandom_range(15) == 0) begin
        r_req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    int a0_cyc, a1_cyc, n_tr, n_wd, ack_cyc;
    int order[$];
    logic got;
    int rdy_pat[6] = '{1, 0, 0, 1, 0, 1};

    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_sel[i] = 1'b0; r_data[i] = 16'h0;
    end
    hready = 1'b1;
    hresp  = 1'b0;
    port0  = 16'h0;
    port1  = 16'h0;
    model_reset();

    // Reset values with a request already pending
    r_req[0] = 1'b1;
    #2;
    check_reset_outputs("por");
    r_req[0] = 1'b0;
    tick();
    do_reset();

    // Single write from client 0
    r_req[0] = 1'b1; r_sel[0] = 1'b0; r_data[0] = 16'h1234;
    eval(); tick();
    eval();
    chk("t1_haddr", bus.HADDR, P0);
    chk("t1_htrans", 32'(bus.HTRANS), 32'd2);
    tick();
    eval();
    chk("t1_hwdata", bus.HWDATA, 32'h00001234);
    chk("t1_ack0", 32'(bus.ack0), 32'd1);
    tick();
    r_req[0] = 1'b0;
    eval(); tick();
    chk("t1_port0", 32'(port0), 32'h1234);

    // Simultaneous requests: client 0 first, then client 1
    do_reset();
    r_req[0] = 1'b1; r_sel[0] = 1'b0; r_data[0] = 16'hAAAA;
    r_req[1] = 1'b1; r_sel[1] = 1'b1; r_data[1] = 16'h5555;
    a0_cyc = -1; a1_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      if (ackd[0]) r_req[0] = 1'b0;
      if (ackd[1]) r_req[1] = 1'b0;
      eval();
      if (bus.ack0 && a0_cyc < 0) a0_cyc = c;
      if (bus.ack1 && a1_cyc < 0) a1_cyc = c;
      tick();
      if (a0_cyc >= 0 && a1_cyc >= 0) break;
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    chk("t2_ack0_cycle", 32'(a0_cyc), 32'd2);
    chk("t2_ack1_cycle", 32'(a1_cyc), 32'd5);
    chk("t2_port0", 32'(port0), 32'hAAAA);
    chk("t2_port1", 32'(port1), 32'h5555);

    // Both clients requesting continuously: alternating grants
    do_reset();
    r_req[0] = 1'b1; r_sel[0] = 1'b0; r_data[0] = 16'h0101;
    r_req[1] = 1'b1; r_sel[1] = 1'b1; r_data[1] = 16'h0202;
    for (int c = 0; c < 18; c++) begin
      for (int i = 0; i < 2; i++) if (ackd[i]) r_data[i] = 16'($urandom);
      eval();
      if (bus.ack0) order.push_back(0);
      if (bus.ack1) order.push_back(1);
      tick();
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    chk("t3_grants", 32'(order.size()), 32'd6);
    for (int k = 0; k < order.size(); k++) chk("t3_order", 32'(order[k]), 32'(k % 2));

    // Wait states: two in ADDR, one in DATA
    do_reset();
    r_req[0] = 1'b1; r_sel[0] = 1'b1; r_data[0] = 16'hBEEF;
    n_tr = 0; n_wd = 0; ack_cyc = -1;
    for (int c = 0; c < 6; c++) begin
      hready = 1'(rdy_pat[c]);
      eval();
      if (bus.HTRANS == 2'b10 && bus.HADDR == P1) n_tr++;
      if (bus.HWDATA == 32'h0000BEEF) n_wd++;
      if (bus.ack0 && ack_cyc < 0) ack_cyc = c;
      tick();
    end
    hready = 1'b1;
    r_req[0] = 1'b0;
    chk("t4_addr_cycles", 32'(n_tr), 32'd3);
    chk("t4_data_cycles", 32'(n_wd), 32'd2);
    chk("t4_ack_cycle", 32'(ack_cyc), 32'd5);
    chk("t4_port1", 32'(port1), 32'hBEEF);

    // Error response pulses err with ack1; next transfer clean
    r_req[1] = 1'b1; r_sel[1] = 1'b1; r_data[1] = 16'h5555;
    hresp = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      eval();
      if (bus.ack1) begin
        got = 1'b1;
        chk("t5_err", 32'(bus.err), 32'd1);
      end
      tick();
    end
    chk("t5_ack_seen", 32'(got), 32'd1);
    hresp = 1'b0;
    r_data[1] = 16'h0F0F;
    eval();
    chk("t5_err_after", 32'(bus.err), 32'd0);
    tick();
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      eval();
      if (bus.ack1) begin
        got = 1'b1;
        chk("t5_err_next", 32'(bus.err), 32'd0);
      end
      tick();
    end
    chk("t5_ack2_seen", 32'(got), 32'd1);
    r_req[1] = 1'b0;

    // Reset during ADDR abandons the write; client 0 wins the tie afterwards
    do_reset();
    r_req[0] = 1'b1; r_sel[0] = 1'b1; r_data[0] = 16'hC0DE;
    eval(); tick();
    eval();
    chk("t6_in_addr", 32'(bus.HTRANS), 32'd2);
    HRESETn = 1'b0;
    #1;
    chk("t6_rst_ctl", 32'({bus.ack0, bus.ack1, bus.HSEL, bus.HTRANS}), 32'd0);
    @(posedge HCLK);
    #1;
    chk("t6_rst_noack", 32'({bus.ack0, bus.ack1}), 32'd0);
    HRESETn = 1'b1;
    model_reset();
    r_req[1] = 1'b1; r_sel[1] = 1'b0; r_data[1] = 16'hD00D;
    eval(); tick();
    eval();
    chk("t6_regrant_addr", bus.HADDR, P1);
    tick();
    eval();
    chk("t6_regrant_ack0", 32'({bus.ack0, bus.ack1}), 32'b10);
    tick();
    r_req[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (ackd[1]) r_req[1] = 1'b0;
      eval(); tick();
    end
    r_req[1] = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_clients();
      hready = ($urandom_range(3) != 0);
      hresp  = ($urandom_range(7) == 0);
      eval();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mfp_ahb_port_write_arbiter.md
# mfp_ahb_port_write_arbiter

Two-requester write scheduler that shares the AHB-Lite port slave (16-bit output registers port0/port1) between two independent on-chip clients. Each client posts a single 16-bit write through a req/ack handshake. The block arbitrates round-robin, then drives one AHB-Lite single write transfer per grant as the bus master on the slave's AHB segment. One transfer is in flight at a time, with no address/data-phase overlap between grants.

## Interface
Parameters:
- PORT0_ADDR, 32'hffff0000, HADDR driven when a client targets port 0
- PORT1_ADDR, 32'hffff0002, HADDR driven when a client targets port 1

Ports:
- HCLK  input  1  clock; one clock, all logic on rising edge
- HRESETn  input  1  reset; asynchronous, active-low
- req0 / req1  input  1  client write request; held high with sel/data stable until ack
- sel0 / sel1  input  1  target port: 0 = PORT0_ADDR, 1 = PORT1_ADDR
- data0 / data1  input  16  write value
- ack0 / ack1  output  1  one-cycle pulse: the client's write data phase completed
- err  output  1  one-cycle pulse coincident with an ack when HRESP was high at completion
- HADDR  output  32  address-phase address
- HTRANS  output  2  2'b10 (NONSEQ) in address phase, else 2'b00 (IDLE)
- HWRITE  output  1  1 in address phase, else 0
- HSIZE  output  3  3'b001 (halfword) constant
- HBURST  output  3  3'b000 (SINGLE) constant
- HSEL  output  1  1 in address phase, else 0
- HWDATA  output  32  {16'b0, latched data} in data phase, else 0
- HREADY  input  1  slave ready
- HRESP  input  1  slave error response

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the client not served last (last_grant register, reset value 1, so client 0 wins the first tie).
  - On grant, latch grant id, HADDR (from sel) and data, then go to ADDR.
- ADDR: drive HTRANS=NONSEQ, HSEL=1, HWRITE=1 and the latched HADDR.
  - HREADY=1: go to DATA.
  - HREADY=0: stay in ADDR, address phase extended, all outputs held.
- DATA: HTRANS=IDLE, HSEL=0, HWRITE=0; HWDATA carries the latched data in bits [15:0].
  - Write data sits in bits [15:0] for both ports, because the slave takes HWDATA[15:0] regardless of address.
  - HREADY=1: ack of the granted client = 1 (combinational, this cycle only); err = HRESP; last_grant <= grant id; go to IDLE.
  - HREADY=0: hold all outputs, no ack.
- Requester rule: the client drops req, or presents a new sel/data with req held, in the cycle after ack. The next IDLE cycle samples req afresh.
- req changes while the client is not granted are legal. A req dropped before grant is simply not served.
- Latched sel/data are immune to input changes after grant.
- Reset values: state=IDLE, last_grant=1, ack0=ack1=err=0, HTRANS=0, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0.
- Reset asserted mid-transfer forces IDLE immediately. The in-flight write is abandoned, no ack is issued, and the client must re-request.

## Timing
- Minimum 3 cycles per write: IDLE (grant) -> ADDR -> DATA(ack). The slave register updates at the end of the DATA cycle.
- Latency from req rising (while idle) to ack: 2 cycles + HREADY wait states.
- Each extra HREADY-low cycle in ADDR or DATA adds exactly one cycle.
- Back-to-back from one client: ack, then IDLE grant on the next cycle, giving 3-cycle throughput.
- Both clients continuously requesting: grants alternate 0,1,0,1.
- ack0 and ack1 are never high together. ack only ever occurs in DATA with HREADY=1.

## Test plan
- Single write, HREADY tied 1: req0, sel0=0, data0=16'h1234 → HADDR=ffff0000/NONSEQ in cycle 2, HWDATA=00001234 in cycle 3 with ack0; port0_out=1234 afterwards.
- Simultaneous req0 (sel=0, data=AAAA) and req1 (sel=1, data=5555) held through two grants → client 0 served first then client 1, ack0 then ack1 three cycles apart; port0=AAAA, port1=5555.
- Continuous req on both for 6 grants → grant order 0,1,0,1,0,1 and no double ack.
- Wait states: HREADY=0 for 2 cycles in ADDR and 1 in DATA → HADDR/HTRANS held 3 cycles, HWDATA held 2 cycles, ack after 5 cycles total.
- Error: HRESP=1 with HREADY=1 in DATA → err pulses with ack1 for one cycle, and err=0 on the next transfer.
- Reset asserted during ADDR → HTRANS=0, HSEL=0, no ack. After release, req0 still high is regranted with last_grant=1, so client 0 wins a tie.
